muscle_spi_responder: RTL and testbench
=======================================

MUSCLE_SPI_RESPONDER -- requirements
Module: muscle_spi_responder

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 12: number of 16-bit words per SPI frame, legal range 3..16.
REQ-002 SHALL have parameter SYNC_WORD, default 16'h8000: required value of the first received word and the fixed first transmitted word.
REQ-003 SHALL have port clock, input, 1: single system clock; all logic on its rising edge; frequency at least 8x sck.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port sck, input, 1: SPI clock from the myocontrol master; asynchronous.
REQ-006 SHALL have port ss_n, input, 1: active-low slave select; asynchronous.
REQ-007 SHALL have port mosi, input, 1: master-to-slave data; asynchronous.
REQ-008 SHALL have port miso, output, 1: slave-to-master data.
REQ-009 SHALL have port position, input, 32: actuator position, snapshotted at frame start.
REQ-010 SHALL have ports velocity, current and displacement, input, 16 each: status values, snapshotted at frame start.
REQ-011 SHALL have port pwm_ref, output, 16 (signed): last accepted PWM reference.
REQ-012 SHALL have port control_flags, output, 16: last accepted control word.
REQ-013 SHALL have port frame_valid, output, 1: one-cycle pulse when a frame is accepted.
REQ-014 SHALL have port frame_error, output, 1: one-cycle pulse when a frame is rejected.

Function
REQ-015 SHALL pass sck, ss_n and mosi each through a 2-flop synchronizer, followed by a third register for edge detection.
REQ-016 SHALL implement SPI mode 0, MSB first: sample mosi on synchronized sck rising edges; update miso on synchronized sck falling edges.
REQ-017 SHALL implement FSM states IDLE, LOAD, SHIFT, CHECK.
- IDLE -> LOAD on a synchronized ss_n falling edge.
- LOAD -> SHIFT after 1 cycle.
- SHIFT -> CHECK on a synchronized ss_n rising edge.
- CHECK -> IDLE after 1 cycle.
REQ-018 In LOAD, SHALL snapshot the inputs into a tx buffer:
- word0 = SYNC_WORD
- word1 = position[31:16], word2 = position[15:0]
- word3 = velocity, word4 = current, word5 = displacement
- words 6..FRAME_WORDS-1 = 16'h0000
REQ-019 SHALL drive word0 bit15 on miso by the end of LOAD, i.e. at most 5 clock cycles after ss_n falls at the pins.
REQ-020 SHALL use a 4-bit bit counter and a word counter; after 16 sampled bits, SHALL store the shifted word at rx[word counter] and increment the word counter.
REQ-021 SHALL saturate the word counter at FRAME_WORDS; words beyond FRAME_WORDS are discarded, and miso outputs 0 for them.
REQ-022 In CHECK, SHALL accept the frame only if all three hold: word counter == FRAME_WORDS, bit counter == 0, and rx[0] == SYNC_WORD.
REQ-023 On accept: SHALL load pwm_ref = rx[1] and control_flags = rx[2], and pulse frame_valid for exactly 1 cycle in the cycle after CHECK.
REQ-024 On reject: SHALL leave pwm_ref and control_flags unchanged and pulse frame_error for 1 cycle in the same timing slot as frame_valid.
REQ-025 frame_valid and frame_error SHALL never be asserted together.
REQ-026 SHALL ignore sck edges while ss_n is high (synchronized), and SHALL hold miso at 0 while not selected.
REQ-027 A ss_n rising edge during LOAD SHALL go directly to CHECK; that frame is rejected.
REQ-028 SHALL reset the bit and word counters on every LOAD.
REQ-029 Input changes after LOAD SHALL not affect the frame in progress.

Reset
REQ-030 On reset, SHALL set: state IDLE, miso 0, pwm_ref 0, control_flags 0, frame_valid 0, frame_error 0, counters 0, synchronizer flops to idle levels (sck 0, ss_n 1, mosi 0).
REQ-031 Reset asserted mid-frame SHALL abort the frame with no pulse; after reset, the block SHALL wait for a fresh ss_n falling edge.

Structure
REQ-032 SHALL place in a shared package (myo_spi_pkg):
- the state enum
- the word-index constants (SYNC, POS_HI, POS_LO, VEL, CUR, DISP, PWM, FLAGS)
- the SYNC_WORD default
REQ-033 SHALL use one sub-module, spi_sync_edge: synchronizer plus rise/fall detection, instantiated once for each of sck, ss_n and mosi.

Verification
REQ-034 Full frame: position=32'h0001_2345, velocity=16'h00AA, current=16'h0BCD, displacement=16'h0077; master sends 8000,FF38,0003,then 9 zeros -> miso words 8000,0001,2345,00AA,0BCD,0077,then zeros; pwm_ref=16'hFF38 (-200), control_flags=16'h0003, one frame_valid pulse.
REQ-035 Bad sync: first word 16'h7FFF, otherwise valid -> frame_error pulse; pwm_ref and control_flags keep their previous values.
REQ-036 Short frame: ss_n deasserted after 11 words -> frame_error; long frame of 13 words -> frame_error, with miso 0 during word 13.
REQ-037 Partial word: ss_n deasserted 5 bits into word 12 -> frame_error; the next correct frame -> frame_valid.
REQ-038 Snapshot: change position to 32'hDEAD_BEEF during word 1 -> that frame returns 0001/2345; the next frame returns DEAD/BEEF.
REQ-039 Reset: assert reset during word 4, release, then send a full valid frame -> no pulse from the aborted frame; the following frame is accepted.

Source files
------------

// File: rtl/myo_spi_pkg.sv
// Shared definitions for the myocontrol SPI responder: FSM states,
// frame word positions and the default sync word.
package myo_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CHECK
    } spi_state_t;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'h8000;

    // Transmit word positions (responder -> master)
    localparam int unsigned IDX_SYNC   = 0;
    localparam int unsigned IDX_POS_HI = 1;
    localparam int unsigned IDX_POS_LO = 2;
    localparam int unsigned IDX_VEL    = 3;
    localparam int unsigned IDX_CUR    = 4;
    localparam int unsigned IDX_DISP   = 5;

    // Receive word positions (master -> responder)
    localparam int unsigned IDX_PWM    = 1;
    localparam int unsigned IDX_FLAGS  = 2;

    // Words carrying status data; all later words transmit as zero
    localparam int unsigned TX_WORDS   = IDX_DISP + 1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus a third
// register so rising/falling edges of the synchronized level can be seen.
module spi_sync_edge #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    // Shift the pin through two metastability flops and one history flop
    always_ff @(posedge clock) begin
        if (reset) begin
            sr <= {3{RESET_LEVEL}};
        end else begin
            sr <= {sr[1:0], async_in};
        end
    end

    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];
    assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/muscle_spi_responder.sv
// SPI mode-0 slave answering the myocontrol master: snapshots actuator
// status at frame start, shifts it out MSB first, and latches the PWM
// reference and control word from a well-formed received frame.
module muscle_spi_responder
    import myo_spi_pkg::*;
#(
    parameter int          FRAME_WORDS = 12,
    parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sck,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    input  logic [31:0] position,
    input  logic [15:0] velocity,
    input  logic [15:0] current,
    input  logic [15:0] displacement,
    output logic [15:0] pwm_ref,
    output logic [15:0] control_flags,
    output logic        frame_valid,
    output logic        frame_error
);

    localparam logic [4:0] FW_CNT = 5'(FRAME_WORDS);

    logic sck_level, sck_rise, sck_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge #(.RESET_LEVEL(1'b0)) u_sync_sck (
        .clock(clock), .reset(reset), .async_in(sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.RESET_LEVEL(1'b1)) u_sync_ss (
        .clock(clock), .reset(reset), .async_in(ss_n),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.RESET_LEVEL(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .async_in(mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sck_level, mosi_rise, mosi_fall};

    spi_state_t  state;
    logic [15:0] tx [0:TX_WORDS-1];
    logic [14:0] rx_shift;
    logic [15:0] rx_sync, rx_pwm, rx_flags;
    logic [3:0]  bit_cnt;
    logic [4:0]  word_cnt;
    logic        overflow;
    logic [1:0]  settle_cnt;
    logic        armed;
    logic        tx_bit;
    logic [15:0] word_in;
    logic        accept;

    // Next miso bit: selected by the counters that already include the bit
    // the master just sampled; anything past the status words is zero
    always_comb begin
        tx_bit = 1'b0;
        if (word_cnt < 5'(TX_WORDS) && word_cnt < FW_CNT) begin
            tx_bit = tx[word_cnt[2:0]][4'd15 - bit_cnt];
        end
    end

    // Word completed by the current sck rising edge
    always_comb begin
        word_in = {rx_shift, mosi_level};
    end

    // Frame acceptance criteria evaluated in CHECK
    always_comb begin
        accept = (word_cnt == FW_CNT) && (bit_cnt == 4'd0) && !overflow
                 && (rx_sync == SYNC_WORD);
    end

    // Frame FSM with registered miso, outputs and result pulses.
    // The saturating word counter cannot tell FRAME_WORDS from FRAME_WORDS+1
    // words, so an overflow flag marks over-long frames for rejection.
    // A frame start is only honoured once ss_n has been seen high after the
    // synchronizer has refilled from the pin, so releasing reset mid-frame
    // cannot fake a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            miso          <= 1'b0;
            pwm_ref       <= '0;
            control_flags <= '0;
            frame_valid   <= 1'b0;
            frame_error   <= 1'b0;
            bit_cnt       <= '0;
            word_cnt      <= '0;
            overflow      <= 1'b0;
            rx_shift      <= '0;
            rx_sync       <= '0;
            rx_pwm        <= '0;
            rx_flags      <= '0;
            settle_cnt    <= '0;
            armed         <= 1'b0;
            for (int unsigned i = 0; i < TX_WORDS; i++) begin
                tx[i] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;

            if (settle_cnt != 2'd2) begin
                settle_cnt <= settle_cnt + 2'd1;
            end else if (ss_level) begin
                armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    miso <= 1'b0;
                    if (ss_fall && armed) begin
                        state    <= ST_LOAD;
                        miso     <= SYNC_WORD[15];
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    tx[IDX_SYNC]   <= SYNC_WORD;
                    tx[IDX_POS_HI] <= position[31:16];
                    tx[IDX_POS_LO] <= position[15:0];
                    tx[IDX_VEL]    <= velocity;
                    tx[IDX_CUR]    <= current;
                    tx[IDX_DISP]   <= displacement;
                    rx_shift       <= '0;
                    rx_sync        <= '0;
                    bit_cnt        <= '0;
                    word_cnt       <= '0;
                    overflow       <= 1'b0;
                    if (ss_rise) begin
                        state <= ST_CHECK;
                        miso  <= 1'b0;
                    end else begin
                        state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (ss_rise) begin
                        state <= ST_CHECK;
                        miso  <= 1'b0;
                    end else if (!ss_level) begin
                        if (sck_rise) begin
                            rx_shift <= word_in[14:0];
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15) begin
                                if (word_cnt == FW_CNT) begin
                                    overflow <= 1'b1;
                                end else begin
                                    word_cnt <= word_cnt + 5'd1;
                                    if (word_cnt == 5'(IDX_SYNC)) begin
                                        rx_sync <= word_in;
                                    end else if (word_cnt == 5'(IDX_PWM)) begin
                                        rx_pwm <= word_in;
                                    end else if (word_cnt == 5'(IDX_FLAGS)) begin
                                        rx_flags <= word_in;
                                    end
                                end
                            end
                        end else if (sck_fall) begin
                            miso <= tx_bit;
                        end
                    end
                end

                ST_CHECK: begin
                    state <= ST_IDLE;
                    miso  <= 1'b0;
                    if (accept) begin
                        pwm_ref       <= rx_pwm;
                        control_flags <= rx_flags;
                        frame_valid   <= 1'b1;
                    end else begin
                        frame_error   <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    miso  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muscle_spi_responder.sv
// Directed bench for muscle_spi_responder: a behavioural SPI master drives
// frames and captures miso; each task checks its own expected values.
module tb_muscle_spi_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        sck;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic [31:0] position;
    logic [15:0] velocity;
    logic [15:0] current;
    logic [15:0] displacement;
    logic [15:0] pwm_ref;
    logic [15:0] control_flags;
    logic        frame_valid;
    logic        frame_error;

    int tests_run    = 0;
    int tests_failed = 0;
    int valid_cycles = 0;
    int error_cycles = 0;
    int both_cycles  = 0;

    logic [15:0] tx_words [0:16];
    logic [15:0] rx_words [0:16];
    int change_pos_word = -1;
    int reset_word      = -1;

    muscle_spi_responder #(.FRAME_WORDS(12), .SYNC_WORD(16'h8000)) dut (
        .clock(clock), .reset(reset), .sck(sck), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .position(position), .velocity(velocity),
        .current(current), .displacement(displacement), .pwm_ref(pwm_ref),
        .control_flags(control_flags), .frame_valid(frame_valid),
        .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    // Count pulse cycles away from the active edge
    always @(negedge clock) begin
        if (frame_valid) valid_cycles++;
        if (frame_error) error_cycles++;
        if (frame_valid && frame_error) both_cycles++;
    end

    task automatic set_frame(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2);
        for (int i = 0; i < 17; i++) tx_words[i] = 16'h0000;
        tx_words[0] = w0;
        tx_words[1] = w1;
        tx_words[2] = w2;
    endtask

    // One frame of n_words full words plus tail_bits extra bits; sck half
    // period is 8 system clocks
    task automatic spi_frame(input int n_words, input int tail_bits);
        @(negedge clock);
        for (int i = 0; i < 17; i++) rx_words[i] = 16'hxxxx;
        ss_n = 1'b0;
        #80;
        for (int w = 0; w < n_words; w++) begin
            for (int b = 15; b >= 0; b--) begin
                mosi = tx_words[w][b];
                if (w == change_pos_word && b == 8) position = 32'hDEAD_BEEF;
                if (w == reset_word && b == 8) begin
                    reset = 1'b1;
                    #30;
                    reset = 1'b0;
                end
                #80;
                rx_words[w][b] = miso;
                sck = 1'b1;
                #80;
                sck = 1'b0;
            end
        end
        for (int b = 0; b < tail_bits; b++) begin
            mosi = 1'b0;
            #80;
            sck = 1'b1;
            #80;
            sck = 1'b0;
        end
        mosi = 1'b0;
        #80;
        ss_n = 1'b1;
        // bounded wait for the result pulse
        #200;
    endtask

    task automatic test_reset;
        tests_run++;
        if (miso !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_miso got %b want 0", miso);
        end
        tests_run++;
        if (pwm_ref !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_pwm got %h want 0000", pwm_ref);
        end
        tests_run++;
        if (control_flags !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_flags got %h want 0000", control_flags);
        end
        tests_run++;
        if (frame_valid !== 1'b0 || frame_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pulses got v=%b e=%b want 0 0", frame_valid, frame_error);
        end
    endtask

    task automatic test_full_frame;
        logic [15:0] exp_words [0:11];
        int v0, e0;
        position = 32'h0001_2345; velocity = 16'h00AA;
        current = 16'h0BCD; displacement = 16'h0077;
        exp_words = '{16'h8000, 16'h0001, 16'h2345, 16'h00AA, 16'h0BCD, 16'h0077,
                      16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        set_frame(16'h8000, 16'hFF38, 16'h0003);
        v0 = valid_cycles; e0 = error_cycles;
        spi_frame(12, 0);
        for (int i = 0; i < 12; i++) begin
            tests_run++;
            if (rx_words[i] !== exp_words[i]) begin
                tests_failed++;
                $display("FAIL full_miso_word%0d got %h want %h", i, rx_words[i], exp_words[i]);
            end
        end
        tests_run++;
        if (pwm_ref !== 16'hFF38) begin
            tests_failed++;
            $display("FAIL full_pwm got %h want ff38", pwm_ref);
        end
        tests_run++;
        if (control_flags !== 16'h0003) begin
            tests_failed++;
            $display("FAIL full_flags got %h want 0003", control_flags);
        end
        tests_run++;
        if (valid_cycles - v0 !== 1 || error_cycles - e0 !== 0) begin
            tests_failed++;
            $display("FAIL full_pulses got v=%0d e=%0d want 1 0", valid_cycles - v0, error_cycles - e0);
        end
    endtask

    task automatic test_bad_sync;
        int v0, e0;
        set_frame(16'h7FFF, 16'h1234, 16'h5678);
        v0 = valid_cycles; e0 = error_cycles;
        spi_frame(12, 0);
        tests_run++;
        if (valid_cycles - v0 !== 0 || error_cycles - e0 !== 1) begin
            tests_failed++;
            $display("FAIL badsync_pulses got v=%0d e=%0d want 0 1", valid_cycles - v0, error_cycles - e0);
        end
        tests_run++;
        if (pwm_ref !== 16'hFF38 || control_flags !== 16'h0003) begin
            tests_failed++;
            $display("FAIL badsync_hold got %h/%h want ff38/0003", pwm_ref, control_flags);
        end
    endtask

    task automatic test_short_frame;
        int v0, e0;
        set_frame(16'h8000, 16'h1111, 16'h2222);
        v0 = valid_cycles; e0 = error_cycles;
        spi_frame(11, 0);
        tests_run++;
        if (valid_cycles - v0 !== 0 || error_cycles - e0 !== 1) begin
            tests_failed++;
            $display("FAIL short_pulses got v=%0d e=%0d want 0 1", valid_cycles - v0, error_cycles - e0);
        end
        tests_run++;
        if (pwm_ref !== 16'hFF38) begin
            tests_failed++;
            $display("FAIL short_hold got %h want ff38", pwm_ref);
        end
    endtask

    task automatic test_long_frame;
        int v0, e0;
        set_frame(16'h8000, 16'h3333, 16'h4444);
        tx_words[12] = 16'hA5A5;
        v0 = valid_cycles; e0 = error_cycles;
        spi_frame(13, 0);
        tests_run++;
        if (valid_cycles - v0 !== 0 || error_cycles - e0 !== 1) begin
            tests_failed++;
            $display("FAIL long_pulses got v=%0d e=%0d want 0 1", valid_cycles - v0, error_cycles - e0);
        end
        tests_run++;
        if (rx_words[12] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL long_miso_word12 got %h want 0000", rx_words[12]);
        end
        tests_run++;
        if (pwm_ref !== 16'hFF38 || control_flags !== 16'h0003) begin
            tests_failed++;
            $display("FAIL long_hold got %h/%h want ff38/0003", pwm_ref, control_flags);
        end
    endtask

    task automatic test_partial_word;
        int v0, e0;
        set_frame(16'h8000, 16'h5555, 16'h6666);
        v0 = valid_cycles; e0 = error_cycles;
        spi_frame(11, 5);
        tests_run++;
        if (valid_cycles - v0 !== 0 || error_cycles - e0 !== 1) begin
            tests_failed++;
            $display("FAIL partial_pulses got v=%0d e=%0d want 0 1", valid_cycles - v0, error_cycles - e0);
        end
        set_frame(16'h8000, 16'h0064, 16'h0005);
        v0 = valid_cycles; e0 = error_cycles;
        spi_frame(12, 0);
        tests_run++;
        if (valid_cycles - v0 !== 1 || error_cycles - e0 !== 0) begin
            tests_failed++;
            $display("FAIL recover_pulses got v=%0d e=%0d want 1 0", valid_cycles - v0, error_cycles - e0);
        end
        tests_run++;
        if (pwm_ref !== 16'h0064 || control_flags !== 16'h0005) begin
            tests_failed++;
            $display("FAIL recover_regs got %h/%h want 0064/0005", pwm_ref, control_flags);
        end
    endtask

    task automatic test_snapshot;
        position = 32'h0001_2345;
        set_frame(16'h8000, 16'h0100, 16'h000A);
        change_pos_word = 1;
        spi_frame(12, 0);
        change_pos_word = -1;
        tests_run++;
        if (rx_words[1] !== 16'h0001 || rx_words[2] !== 16'h2345) begin
            tests_failed++;
            $display("FAIL snap_old got %h/%h want 0001/2345", rx_words[1], rx_words[2]);
        end
        spi_frame(12, 0);
        tests_run++;
        if (rx_words[1] !== 16'hDEAD || rx_words[2] !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL snap_new got %h/%h want dead/beef", rx_words[1], rx_words[2]);
        end
    endtask

    task automatic test_load_abort;
        int v0, e0;
        v0 = valid_cycles; e0 = error_cycles;
        @(negedge clock);
        ss_n = 1'b0;
        @(negedge clock);
        ss_n = 1'b1;
        repeat (20) @(negedge clock);
        tests_run++;
        if (valid_cycles - v0 !== 0 || error_cycles - e0 !== 1) begin
            tests_failed++;
            $display("FAIL abort_pulses got v=%0d e=%0d want 0 1", valid_cycles - v0, error_cycles - e0);
        end
        tests_run++;
        if (miso !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_miso got %b want 0", miso);
        end
    endtask

    task automatic test_reset_midframe;
        int v0, e0;
        set_frame(16'h8000, 16'h7777, 16'h0008);
        reset_word = 4;
        spi_frame(12, 0);
        reset_word = -1;
        // pulses counted only from the reset release onward are zero if the
        // aborted frame produced none; check registers were cleared instead
        tests_run++;
        if (pwm_ref !== 16'h0000 || control_flags !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_regs got %h/%h want 0000/0000", pwm_ref, control_flags);
        end
        set_frame(16'h8000, 16'hFFFF, 16'h00F0);
        v0 = valid_cycles; e0 = error_cycles;
        spi_frame(12, 0);
        tests_run++;
        if (valid_cycles - v0 !== 1 || error_cycles - e0 !== 0) begin
            tests_failed++;
            $display("FAIL rst_next_pulses got v=%0d e=%0d want 1 0", valid_cycles - v0, error_cycles - e0);
        end
        tests_run++;
        if (pwm_ref !== 16'hFFFF || control_flags !== 16'h00F0) begin
            tests_failed++;
            $display("FAIL rst_next_regs got %h/%h want ffff/00f0", pwm_ref, control_flags);
        end
    endtask

    task automatic test_reset_no_pulse;
        int v0, e0;
        set_frame(16'h8000, 16'h1357, 16'h0009);
        reset_word = 4;
        v0 = valid_cycles; e0 = error_cycles;
        spi_frame(12, 0);
        reset_word = -1;
        tests_run++;
        if (valid_cycles - v0 !== 0 || error_cycles - e0 !== 0) begin
            tests_failed++;
            $display("FAIL rst_abort_pulses got v=%0d e=%0d want 0 0", valid_cycles - v0, error_cycles - e0);
        end
    endtask

    initial begin
        reset = 1'b1; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        position = '0; velocity = '0; current = '0; displacement = '0;
        for (int i = 0; i < 17; i++) begin
            tx_words[i] = 16'h0000;
            rx_words[i] = 16'h0000;
        end
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        repeat (5) @(negedge clock);
        test_full_frame();
        test_bad_sync();
        test_short_frame();
        test_long_frame();
        test_partial_word();
        test_snapshot();
        test_load_abort();
        test_reset_no_pulse();
        test_reset_midframe();
        tests_run++;
        if (both_cycles !== 0) begin
            tests_failed++;
            $display("FAIL both_pulses got %0d cycles want 0", both_cycles);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
